alert: RTL and testbench

ALERT -- requirements
Module: alert

---
 rtl/alert_pkg.sv | 20 ++
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/alert.sv | 117 +++++++++++
 tb/tb_alert.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/alert_pkg.sv
// Shared constants for the mm:ss stopwatch: seven-segment digit patterns
// (active-low, {g,f,e,d,c,b,a}) and the wrap limits for seconds and minutes.
package alert_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [5:0] MAX_SEC = 6'd59;
   localparam logic [5:0] MAX_MIN = 6'd59;

endpackage

// File: rtl/bcd_to_seg7.sv
// Four-bit digit to active-low seven-segment pattern; non-decimal codes blank.
module bcd_to_seg7
   import alert_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);

   // Digit lookup; anything outside 0..9 turns every segment off.
   always_comb begin
      o_seg = SEG_BLANK;
      case (i_bcd)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/alert.sv
// mm:ss count-up stopwatch. KEY[0] is an asynchronous active-low reset,
// KEY[1] an active-low start/stop button synchronised into clk. A divider
// produces one tick per CLK_FREQ cycles while running and freezes while
// stopped so a partial second survives a stop/start.
module alert
   import alert_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000
)
(
   input  logic       clk,
   input  logic [1:0] KEY,
   output logic [6:0] hex0,
   output logic [6:0] hex1,
   output logic [6:0] hex2,
   output logic [6:0] hex3
);

   localparam int              DIV_W    = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_FREQ - 1);

   logic             rst_n;
   logic             r_key_s1;
   logic             r_key_s2;
   logic             r_key_prev;
   logic             w_press;
   logic             run;
   logic [DIV_W-1:0] r_div;
   logic             w_tick;
   logic [5:0]       giay;
   logic [5:0]       phut;
   logic [3:0]       w_sec_ones;
   logic [3:0]       w_sec_tens;
   logic [3:0]       w_min_ones;
   logic [3:0]       w_min_tens;

   assign rst_n = KEY[0];

   // Two-flop synchroniser plus one history flop; all park at released (1).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key_s1   <= 1'b1;
         r_key_s2   <= 1'b1;
         r_key_prev <= 1'b1;
      end else begin
         r_key_s1   <= KEY[1];
         r_key_s2   <= r_key_s1;
         r_key_prev <= r_key_s2;
      end
   end

   // A press is the synchronised high-to-low transition; holding is ignored.
   assign w_press = r_key_prev & ~r_key_s2;

   // Run/stop bit toggles once per detected press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run <= 1'b0;
      end else if (w_press) begin
         run <= ~run;
      end else begin
         run <= run;
      end
   end

   // One-second divider; holds its count while stopped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div <= '0;
      end else if (run) begin
         if (r_div >= DIV_LAST) begin
            r_div <= '0;
         end else begin
            r_div <= r_div + 1'b1;
         end
      end else begin
         r_div <= r_div;
      end
   end

   // Tick uses the current run value, so a coincident press still counts it.
   assign w_tick = run & (r_div >= DIV_LAST);

   // Seconds/minutes counters with wrap at 59 and 59:59 -> 00:00.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         giay <= 6'd0;
         phut <= 6'd0;
      end else if (w_tick) begin
         if (giay >= MAX_SEC) begin
            giay <= 6'd0;
            if (phut >= MAX_MIN) begin
               phut <= 6'd0;
            end else begin
               phut <= phut + 6'd1;
            end
         end else begin
            giay <= giay + 6'd1;
            phut <= phut;
         end
      end else begin
         giay <= giay;
         phut <= phut;
      end
   end

   assign w_sec_ones = 4'(giay % 6'd10);
   assign w_sec_tens = 4'(giay / 6'd10);
   assign w_min_ones = 4'(phut % 6'd10);
   assign w_min_tens = 4'(phut / 6'd10);

   bcd_to_seg7 u_seg0 (.i_bcd(w_sec_ones), .o_seg(hex0));
   bcd_to_seg7 u_seg1 (.i_bcd(w_sec_tens), .o_seg(hex1));
   bcd_to_seg7 u_seg2 (.i_bcd(w_min_ones), .o_seg(hex2));
   bcd_to_seg7 u_seg3 (.i_bcd(w_min_tens), .o_seg(hex3));

endmodule

// File: tb/tb_alert.sv
// Randomised self-checking bench for the alert stopwatch. The reference
// model tracks elapsed whole seconds (mod 3600) and the fractional phase of
// the current second; a press takes effect on the third clock edge after the
// button goes low.
module tb_alert;

   localparam int FREQ = 10;

   logic       clk;
   logic [1:0] key;
   logic [6:0] hex0, hex1, hex2, hex3;

   int n_checks = 0;
   int n_errors = 0;

   int m_cyc   = 0;
   int m_due   = -1;
   int m_phase = 0;
   int m_el    = 0;
   bit m_run   = 1'b0;

   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

   alert #(.CLK_FREQ(FREQ)) dut (
      .clk (clk),
      .KEY (key),
      .hex0(hex0),
      .hex1(hex1),
      .hex2(hex2),
      .hex3(hex3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_run   = 1'b0;
      m_phase = 0;
      m_el    = 0;
      m_due   = -1;
   endtask

   // Advance the model by one rising edge.
   task automatic model_edge();
      m_cyc++;
      if (m_run) begin
         if (m_phase == FREQ - 1) begin
            m_phase = 0;
            m_el    = (m_el + 1) % 3600;
         end else begin
            m_phase++;
         end
      end
      if (m_cyc == m_due) m_run = !m_run;
   endtask

   task automatic compare_all();
      int s, m;
      s = m_el % 60;
      m = m_el / 60;
      check_eq("giay", dut.giay, s);
      check_eq("phut", dut.phut, m);
      check_eq("run",  dut.run, m_run);
      check_eq("hex0", hex0, seg_tab[s % 10]);
      check_eq("hex1", hex1, seg_tab[s / 10]);
      check_eq("hex2", hex2, seg_tab[m % 10]);
      check_eq("hex3", hex3, seg_tab[m / 10]);
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_edge();
         #1;
         compare_all();
      end
   endtask

   // Called 1 ns after a rising edge; low for 'hold' cycles, then released.
   task automatic press(input int hold, input int gap);
      key[1] = 1'b0;
      m_due  = m_cyc + 3;
      step(hold);
      key[1] = 1'b1;
      step(gap);
   endtask

   task automatic run_until(input int target, input int budget, input string tag);
      int n;
      n = 0;
      while (m_el != target && n < budget) begin
         step(1);
         n++;
      end
      check_eq(tag, dut.phut * 60 + dut.giay, target);
   endtask

   initial begin
      key = 2'b10;
      #10 key = 2'b00;
      #15 key = 2'b10;
      #15;
      check_eq("rst_hex0", hex0, 7'b1000000);
      check_eq("rst_hex1", hex1, 7'b1000000);
      check_eq("rst_hex2", hex2, 7'b1000000);
      check_eq("rst_hex3", hex3, 7'b1000000);
      check_eq("rst_giay", dut.giay, 0);
      check_eq("rst_phut", dut.phut, 0);
      check_eq("rst_run",  dut.run, 0);
      @(negedge clk);
      key = 2'b11;
      model_reset();

      step(200);

      press(2, 4);
      check_eq("run_on", dut.run, 1);
      run_until(1, 7, "first_sec");
      check_eq("first_hex0", hex0, 7'b1111001);

      step($urandom_range(2, 8));
      press(2, 4);
      check_eq("run_off", dut.run, 0);
      step(100);
      press(2, 4);

      run_until(60, 700, "one_min");
      check_eq("one_min_giay", dut.giay, 0);
      check_eq("one_min_hex2", hex2, 7'b1111001);

      for (int k = 0; k < 10; k++) begin
         step($urandom_range(1, 40));
         press($urandom_range(1, 5), $urandom_range(4, 8));
      end
      if (!m_run) press(2, 4);

      run_until(3599, 40000, "to_5959");
      run_until(0, 12, "wrap");

      step($urandom_range(3, 9));
      #1 key[0] = 1'b0;
      model_reset();
      #1;
      check_eq("mid_rst_giay", dut.giay, 0);
      check_eq("mid_rst_phut", dut.phut, 0);
      check_eq("mid_rst_run",  dut.run, 0);
      check_eq("mid_rst_hex0", hex0, 7'b1000000);
      check_eq("mid_rst_hex3", hex3, 7'b1000000);
      repeat (2) @(negedge clk);
      key = 2'b11;
      step(30);
      press(2, 4);
      run_until(2, 40, "restart");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
